system_led_pio: RTL and testbench

- Avalon-MM write-side parallel output port: the output counterpart of the system key input PIO, driving board LEDs from the Nios II data master.
- Holds an output data register with atomic set/clear aliases and a hardware blink engine. A selected mask of bits toggles at a software-programmed period, so there is no CPU polling.
- Sits on the system interconnect as an s1 Avalon slave; out_port goes to the top-level LED pins.

---
 rtl/system_led_pio.sv | 130 +++++++++++++
 tb/tb_system_led_pio.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_led_pio.sv
// system_led_pio
// Avalon-MM write-side parallel output port driving board LEDs.
//
// Holds an output data register with atomic set/clear aliases, plus a blink
// engine. Bits selected by the blink mask are forced low during the "on" phase
// of a software-programmed period. This lets the LEDs flash without CPU polling.
//
// Ports:
//   clk        - system clock; all logic on the rising edge
//   reset_n    - synchronous active-low reset
//   address    - register word address (0 DATA, 1 BLINK_MASK, 2 PERIOD,
//                3 STATUS, 4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect - slave select, active high
//   write_n    - write strobe, active low
//   writedata  - write data; only the low DATA_WIDTH / PERIOD_W bits are used
//   readdata   - registered read data, zero-extended
//   out_port   - LED drive
//
// Build option:
//   SYSTEM_LED_PIO_READBACK_EN - when defined, readdata returns the register
//   selected by address one cycle later. When undefined, the port is
//   write-only and readdata is tied to 0.
//
// Bus handshake: there are no wait states. A write is accepted on any rising
// edge where chipselect=1 and write_n=0. Its effect is visible on out_port
// right after that edge.

module system_led_pio #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    PERIOD_W    = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    logic [DATA_WIDTH-1:0] data_reg;
    logic [DATA_WIDTH-1:0] mask_reg;
    logic [PERIOD_W-1:0]   period_reg;
    logic [PERIOD_W-1:0]   cnt;
    logic                  phase;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [PERIOD_W-1:0]   wdata_p;

    // Upper writedata bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    assign wr      = chipselect & ~write_n;
    assign wdata_d = writedata[DATA_WIDTH-1:0];
    assign wdata_p = writedata[PERIOD_W-1:0];

    // Data and mask registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg <= RESET_VALUE;
            mask_reg <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data_reg <= wdata_d;
                ADDR_MASK:     mask_reg <= wdata_d;
                ADDR_OUTSET:   data_reg <= data_reg | wdata_d;
                ADDR_OUTCLEAR: data_reg <= data_reg & ~wdata_d;
                default:       ;
            endcase
        end
    end

    // Blink engine. A PERIOD write restarts the count and phase on the same
    // edge, so it takes priority over any toggle that would have happened.
    // With period_reg != 0, each phase level lasts period_reg+1 cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_reg <= '0;
            cnt        <= '0;
            phase      <= 1'b0;
        end else if (wr && address == ADDR_PERIOD) begin
            period_reg <= wdata_p;
            cnt        <= wdata_p;
            phase      <= 1'b0;
        end else if (period_reg == '0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == '0) begin
            cnt   <= period_reg;
            phase <= ~phase;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Driven only from flops, so address decode cannot glitch the LEDs.
    assign out_port = data_reg & ~(mask_reg & {DATA_WIDTH{phase}});

`ifdef SYSTEM_LED_PIO_READBACK_EN
    // Reads are not gated by chipselect. The interconnect only samples
    // readdata for its own read cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA:   readdata <= 32'(data_reg);
                ADDR_MASK:   readdata <= 32'(mask_reg);
                ADDR_PERIOD: readdata <= 32'(period_reg);
                ADDR_STATUS: readdata <= {31'b0, phase};
                default:     readdata <= '0;
            endcase
        end
    end
`else
    assign readdata = 32'd0;
`endif

endmodule

// File: tb/tb_system_led_pio.sv
// Directed testbench for system_led_pio with RESET_VALUE = 8'hA5.

module tb_system_led_pio;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_cmp;
    int n_err;

    system_led_pio #(
        .DATA_WIDTH (8),
        .PERIOD_W   (24),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus write: driven at the falling edge, accepted on the next rising edge.
    // Returns just after the accepting edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Bus read: returns just after the edge that registers readdata.
    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_port !== 8'hA5) begin
            $display("FAIL reset_out: got %h expected a5", out_port);
            n_err++;
        end
        n_cmp++;
        if (readdata !== 32'd0) begin
            $display("FAIL reset_readdata: got %h expected 0", readdata);
            n_err++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd3);
        n_cmp++;
        if (readdata !== 32'd0) begin
            $display("FAIL reset_status: got %h expected 0", readdata);
            n_err++;
        end
        n_cmp++;
        if (out_port !== 8'hA5) begin
            $display("FAIL reset_release_out: got %h expected a5", out_port);
            n_err++;
        end
    endtask

    task automatic test_set_clear();
        bus_write(3'd0, 32'h0000_00F0);
        n_cmp++;
        if (out_port !== 8'hF0) begin
            $display("FAIL data_write: got %h expected f0", out_port);
            n_err++;
        end
        bus_write(3'd4, 32'h0000_000F);
        n_cmp++;
        if (out_port !== 8'hFF) begin
            $display("FAIL outset: got %h expected ff", out_port);
            n_err++;
        end
        bus_write(3'd5, 32'h0000_0081);
        n_cmp++;
        if (out_port !== 8'h7E) begin
            $display("FAIL outclear: got %h expected 7e", out_port);
            n_err++;
        end
        // Write strobe without chipselect must do nothing.
        @(negedge clk);
        address    = 3'd0;
        writedata  = 32'h0;
        chipselect = 1'b0;
        write_n    = 1'b0;
        tick();
        write_n = 1'b1;
        n_cmp++;
        if (out_port !== 8'h7E) begin
            $display("FAIL no_cs_write: got %h expected 7e", out_port);
            n_err++;
        end
        // Writes to STATUS and reserved addresses are ignored.
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd6, 32'h0000_0000);
        bus_write(3'd7, 32'h0000_0000);
        n_cmp++;
        if (out_port !== 8'h7E) begin
            $display("FAIL reserved_write: got %h expected 7e", out_port);
            n_err++;
        end
    endtask

    task automatic test_blink();
        logic [7:0] exp;
        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd1, 32'h0000_000F);
        n_cmp++;
        if (out_port !== 8'hFF) begin
            $display("FAIL mask_idle: got %h expected ff", out_port);
            n_err++;
        end
        bus_write(3'd2, 32'd3);
        n_cmp++;
        if (out_port !== 8'hFF) begin
            $display("FAIL period_start: got %h expected ff", out_port);
            n_err++;
        end
        // Each level lasts 4 cycles: FF after edges 0..3, F0 after 4..7, ...
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp = (((k / 4) % 2) == 1) ? 8'hF0 : 8'hFF;
            n_cmp++;
            if (out_port !== exp) begin
                $display("FAIL blink_k%0d: got %h expected %h", k, out_port, exp);
                n_err++;
            end
        end
        // Edge 13 left phase=1 (F0) mid-phase. PERIOD=0 returns to FF.
        bus_write(3'd2, 32'd0);
        n_cmp++;
        if (out_port !== 8'hFF) begin
            $display("FAIL period_zero: got %h expected ff", out_port);
            n_err++;
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (out_port !== 8'hFF) begin
                $display("FAIL idle_hold_%0d: got %h expected ff", k, out_port);
                n_err++;
            end
        end
    endtask

    task automatic test_toggle_collision();
        bus_write(3'd0, 32'h0000_0030);
        bus_write(3'd1, 32'h0000_00F0);
        bus_write(3'd2, 32'd2);   // edge E0: cnt=2, phase=0
        tick();                   // E1
        tick();                   // E2
        n_cmp++;
        if (out_port !== 8'h30) begin
            $display("FAIL pre_toggle: got %h expected 30", out_port);
            n_err++;
        end
        bus_write(3'd4, 32'h0000_0001);  // E3: toggle to phase=1 and OUTSET
        n_cmp++;
        if (out_port !== 8'h01) begin
            $display("FAIL toggle_outset: got %h expected 01", out_port);
            n_err++;
        end
        tick();   // E4
        tick();   // E5
        n_cmp++;
        if (out_port !== 8'h01) begin
            $display("FAIL phase1_hold: got %h expected 01", out_port);
            n_err++;
        end
        tick();   // E6: toggle back to phase=0
        n_cmp++;
        if (out_port !== 8'h31) begin
            $display("FAIL phase0_return: got %h expected 31", out_port);
            n_err++;
        end
    endtask

    task automatic test_reset_during_blink();
        bus_write(3'd0, 32'h0000_00FF);
        bus_write(3'd1, 32'h0000_000F);
        bus_write(3'd2, 32'd5);   // E0
        for (int k = 0; k < 7; k++) tick();   // through E7, phase=1 since E6
        n_cmp++;
        if (out_port !== 8'hF0) begin
            $display("FAIL blink5_phase1: got %h expected f0", out_port);
            n_err++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if (out_port !== 8'hA5) begin
            $display("FAIL mid_reset_out: got %h expected a5", out_port);
            n_err++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        // A full mask makes any stray toggle visible as 00.
        bus_write(3'd1, 32'h0000_00FF);
        for (int k = 0; k < 15; k++) begin
            tick();
            n_cmp++;
            if (out_port !== 8'hA5) begin
                $display("FAIL post_reset_idle_%0d: got %h expected a5", k, out_port);
                n_err++;
            end
        end
        bus_write(3'd2, 32'd1);   // E0: phase=0
        tick();                   // E1
        tick();                   // E2: toggle to phase=1
        n_cmp++;
        if (out_port !== 8'h00) begin
            $display("FAIL restart_blink: got %h expected 00", out_port);
            n_err++;
        end
        bus_write(3'd2, 32'd0);
    endtask

    task automatic test_readback();
        logic [31:0] exp_period;
        logic [31:0] exp_data;
`ifdef SYSTEM_LED_PIO_READBACK_EN
        exp_period = 32'h0012_3456;
        exp_data   = 32'h0000_005A;
`else
        exp_period = 32'h0;
        exp_data   = 32'h0;
`endif
        bus_write(3'd2, 32'hAB12_3456);
        bus_read(3'd2);
        n_cmp++;
        if (readdata !== exp_period) begin
            $display("FAIL read_period: got %h expected %h", readdata, exp_period);
            n_err++;
        end
        bus_write(3'd2, 32'd0);
        bus_write(3'd0, 32'h0000_005A);
        bus_read(3'd0);
        n_cmp++;
        if (readdata !== exp_data) begin
            $display("FAIL read_data: got %h expected %h", readdata, exp_data);
            n_err++;
        end
        bus_read(3'd6);
        n_cmp++;
        if (readdata !== 32'd0) begin
            $display("FAIL read_reserved: got %h expected 0", readdata);
            n_err++;
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        test_reset();
        test_set_clear();
        test_blink();
        test_toggle_collision();
        test_reset_during_blink();
        test_readback();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
